muldiv_ctrl: RTL

Sequencer for the shared iterative multiply/divide unit that backs the MIPS HI/LO instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO; MFHI/MFLO read its outputs). It sits beside the execute stage. It accepts one operation at a time from decode with operands already forwarded, runs a 32-step shift-add or restoring-divide loop, and owns the HI/LO registers. It raises a stall toward decode whenever a new HI/LO operation or an MFHI/MFLO read meets a busy unit.

---
 rtl/muldiv_ctrl_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op encodings, FSM states and a conditional two's-complement helper.
package muldiv_ctrl_pkg;

   localparam int unsigned Width = 32;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {
      StIdle,
      StIter,
      StFix
   } md_state_e;

   function automatic logic [Width-1:0] neg_if(input logic [Width-1:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply (add-then-shift-right) or
// restoring divide (shift-subtract) loop over a 64-bit accumulator.
module muldiv_step
   import muldiv_ctrl_pkg::*;
(
   input  logic               is_div_i,
   input  logic [2*Width-1:0] acc_i,
   input  logic [Width-1:0]   opnd_i,
   output logic [2*Width-1:0] acc_o,
   output logic               q_bit_o
);

   logic [Width:0] sum;
   logic [Width:0] rem_sh;
   logic [Width:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i[2*Width-1:Width]} + {1'b0, opnd_i};
      rem_sh  = acc_i[2*Width-1:Width-1];
      diff    = rem_sh - {1'b0, opnd_i};
      q_bit_o = 1'b0;
      acc_o   = acc_i;
      if (is_div_i) begin
         // Borrow out of the 33-bit subtract means the divisor did not fit.
         q_bit_o = ~diff[Width];
         acc_o   = {(q_bit_o ? diff[Width-1:0] : rem_sh[Width-1:0]), acc_i[Width-2:0], 1'b0};
      end else if (acc_i[0]) begin
         acc_o = {sum, acc_i[Width-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[2*Width-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative HI/LO multiply/divide unit: accepts one op at a
// time, runs 32 steps, fixes up signs and owns the HI/LO registers.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        read_hilo,
   input  logic        cancel,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic        is_div_q, is_div_d;
   logic        res_neg_q, res_neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic        div_zero_q, div_zero_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] step_acc;
   logic        step_q_bit;
   logic        is_signed;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic [63:0] prod_fix;

   muldiv_step u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (step_acc),
      .q_bit_o  (step_q_bit)
   );

   assign is_signed = ~op[0];
   assign rs_mag    = neg_if(rs_data, is_signed & rs_data[31]);
   assign rt_mag    = neg_if(rt_data, is_signed & rt_data[31]);
   assign prod_fix  = res_neg_q ? (~acc_q + 64'd1) : acc_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      res_neg_d  = res_neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;

      unique case (state_q)
         StIdle: begin
            if (start && !cancel) begin
               case (op)
                  OpMthi: begin
                     hi_d       = rs_data;
                     div_zero_d = 1'b0;
                  end
                  OpMtlo: begin
                     lo_d       = rs_data;
                     div_zero_d = 1'b0;
                  end
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     cnt_d      = 5'd31;
                     is_div_d   = op[1];
                     res_neg_d  = is_signed & (rs_data[31] ^ rt_data[31]);
                     rem_neg_d  = is_signed & rs_data[31];
                     div_zero_d = 1'b0;
                     state_d    = StIter;
                     if (op[1]) begin
                        opnd_d = rt_mag;
                        acc_d  = {32'd0, rs_mag};
                        if (rt_data == 32'd0) begin
                           // Preload the fix-up so the remainder path restores rs and lo is all ones.
                           acc_d      = {rs_mag, 32'hFFFF_FFFF};
                           res_neg_d  = 1'b0;
                           div_zero_d = 1'b1;
                           state_d    = StFix;
                        end
                     end else begin
                        opnd_d = rs_mag;
                        acc_d  = {32'd0, rt_mag};
                     end
                  end
                  default: ;
               endcase
            end
         end
         StIter: begin
            if (cancel) begin
               state_d = StIdle;
            end else begin
               acc_d = step_acc | {63'd0, step_q_bit};
               if (cnt_q == 5'd0) begin
                  state_d = StFix;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = neg_if(acc_q[63:32], rem_neg_q);
                  lo_d = neg_if(acc_q[31:0], res_neg_q);
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         acc_q      <= 64'd0;
         opnd_q     <= 32'd0;
         is_div_q   <= 1'b0;
         res_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         res_neg_q  <= res_neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign stall    = busy & (start | read_hilo);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
